dmem_ctrl: RTL and testbench

Parametrised successor to the team's word-only data memory: a synchronous single-port data RAM for the MIPS datapath with byte/half/word access, sign/zero extension, alignment checking and a post-reset clear sequencer. It sits between the ALU address output and the writeback mux. A registered read returns data one cycle after the request with a valid strobe. A busy signal stalls the pipeline while the array is being cleared.

---
 rtl/dmem_ctrl_if.sv | 37 +++
 rtl/dmem_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the pipeline and the data memory.
// The parity_err response exists only when DMEM_PARITY_EN is defined.
interface dmem_ctrl_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH+1:0] addr;
  logic [31:0]           din;
  logic                  wen;
  logic                  ren;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [31:0]           dout;
  logic                  rvalid;
  logic                  misalign;
  logic                  busy;
`ifdef DMEM_PARITY_EN
  logic                  parity_err;
`endif

  // Pipeline side: issues requests, consumes load results.
  modport master (
    output addr, din, wen, ren, size, sign_ext,
`ifdef DMEM_PARITY_EN
    input  parity_err,
`endif
    input  dout, rvalid, misalign, busy
  );

  // Memory side: accepts requests, returns load results.
  modport slave (
    input  addr, din, wen, ren, size, sign_ext,
`ifdef DMEM_PARITY_EN
    output parity_err,
`endif
    output dout, rvalid, misalign, busy
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Single-port 32-bit data RAM with byte/half/word access, sign/zero
// extension, alignment checking and a post-reset clear sequencer.
// Optional feature macro: DMEM_PARITY_EN (per-lane even parity + parity_err).
// Storage is split into four byte-lane arrays so each lane has its own
// write enable; a load registers all four lanes and the lane/size
// selection is applied to the registered word.
module dmem_ctrl #(
  parameter int ADDR_WIDTH     = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  dmem_ctrl_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef DMEM_PARITY_EN
  localparam int LANE_W = 9;  // data byte plus its even-parity bit
`else
  localparam int LANE_W = 8;
`endif

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] clear_idx_reg, clear_idx_next;

  // Request decode
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [1:0]            req_lane;
  logic                  req_legal;
  logic [3:0]            req_mask;
  logic                  do_store;
  logic                  do_load;
  logic                  do_bad;

  // Shared write port (clear sequencer or store)
  logic [3:0]            lane_we;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [31:0]           wr_data;

  // Registered load state
  logic [31:0]           rd_word;
  logic [1:0]            rd_lsel_reg;
  logic [1:0]            rd_size_reg;
  logic                  rd_sign_reg;
  logic                  rvalid_reg;
  logic                  misalign_reg;
  logic [31:0]           load_data;
`ifdef DMEM_PARITY_EN
  logic [3:0]            rd_mask_reg;
  logic [3:0]            rd_par_bad;
`endif

  assign req_idx  = bus.addr[ADDR_WIDTH+1:2];
  assign req_lane = bus.addr[1:0];

  // Legality and touched-lane mask for the current request
  always_comb begin
    req_legal = 1'b0;
    req_mask  = 4'b0000;
    case (bus.size)
      2'b00: begin
        req_legal = 1'b1;
        req_mask  = 4'b0001 << req_lane;
      end
      2'b01: begin
        req_legal = ~req_lane[0];
        req_mask  = req_lane[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        req_legal = (req_lane == 2'b00);
        req_mask  = 4'b1111;
      end
      default: begin
        req_legal = 1'b0;
        req_mask  = 4'b0000;
      end
    endcase
  end

  // FSM state register and clear index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clear_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      clear_idx_reg <= clear_idx_next;
    end
  end

  // FSM next state: walk every word once, then stay idle
  always_comb begin
    state_next     = state_reg;
    clear_idx_next = clear_idx_reg;
    case (state_reg)
      ST_CLEAR: begin
        clear_idx_next = clear_idx_reg + 1'b1;
        if (&clear_idx_reg) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: request strobes, busy and write-port steering
  always_comb begin
    do_store = 1'b0;
    do_load  = 1'b0;
    do_bad   = 1'b0;
    lane_we  = 4'b0000;
    wr_idx   = req_idx;
    wr_data  = 32'h0000_0000;
    bus.busy = (state_reg == ST_CLEAR) | ~reset;
    case (state_reg)
      ST_CLEAR: begin
        lane_we = 4'b1111;
        wr_idx  = clear_idx_reg;
        wr_data = 32'h0000_0000;
      end
      default: begin
        do_bad   = (bus.wen | bus.ren) & ~req_legal;
        do_store = bus.wen & req_legal;
        // Store wins over a simultaneous load
        do_load  = bus.ren & ~bus.wen & req_legal;
        lane_we  = do_store ? req_mask : 4'b0000;
        case (bus.size)
          2'b00:   wr_data = {4{bus.din[7:0]}};
          2'b01:   wr_data = {2{bus.din[15:0]}};
          default: wr_data = bus.din;
        endcase
      end
    endcase
  end

  // Per-lane storage with its own write enable and registered read
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [LANE_W-1:0] mem_lane [DEPTH];
    logic [LANE_W-1:0] wr_lane;
    logic [LANE_W-1:0] rd_lane_reg;

`ifdef DMEM_PARITY_EN
    assign wr_lane = {^wr_data[gi*8 +: 8], wr_data[gi*8 +: 8]};
    // Even parity over data plus parity bit must come out zero
    assign rd_par_bad[gi] = ^rd_lane_reg;
`else
    assign wr_lane = wr_data[gi*8 +: 8];
`endif

    // Lane write: clear sequencer or enabled store
    always_ff @(posedge clk) begin
      if (lane_we[gi]) begin
        mem_lane[wr_idx] <= wr_lane;
      end
    end

    // Lane read: captured only on an accepted load so dout holds otherwise
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_lane_reg <= '0;
      end else if (do_load) begin
        rd_lane_reg <= mem_lane[req_idx];
      end
    end

    assign rd_word[gi*8 +: 8] = rd_lane_reg[7:0];
  end

  // Load metadata and one-cycle response strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_lsel_reg  <= 2'b00;
      rd_size_reg  <= 2'b00;
      rd_sign_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      misalign_reg <= 1'b0;
`ifdef DMEM_PARITY_EN
      rd_mask_reg  <= 4'b0000;
`endif
    end else begin
      rvalid_reg   <= do_load;
      misalign_reg <= do_bad;
      if (do_load) begin
        rd_lsel_reg <= req_lane;
        rd_size_reg <= bus.size;
        rd_sign_reg <= bus.sign_ext;
`ifdef DMEM_PARITY_EN
        rd_mask_reg <= req_mask;
`endif
      end
    end
  end

  // Lane extraction and sign/zero extension of the registered word
  always_comb begin
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    sel_byte  = rd_word[{rd_lsel_reg, 3'b000} +: 8];
    sel_half  = rd_lsel_reg[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    case (rd_size_reg)
      2'b00:   load_data = {{24{rd_sign_reg & sel_byte[7]}}, sel_byte};
      2'b01:   load_data = {{16{rd_sign_reg & sel_half[15]}}, sel_half};
      default: load_data = rd_word;
    endcase
  end

  assign bus.dout     = load_data;
  assign bus.rvalid   = rvalid_reg;
  assign bus.misalign = misalign_reg;
`ifdef DMEM_PARITY_EN
  assign bus.parity_err = rvalid_reg & |(rd_mask_reg & rd_par_bad);
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed plan steps followed by
// random traffic, checked against a word-array reference model.
module tb_dmem_ctrl;

  localparam int AW    = 10;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_dout = 32'h0;
  logic        exp_perr = 1'b0;

  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  dmem_ctrl #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [1:0] lane, input logic [1:0] sz);
    case (sz)
      2'd0:    return 1'b1;
      2'd1:    return lane[0] == 1'b0;
      2'd2:    return lane == 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [1:0] sz, input logic sx);
    logic [31:0] v;
    v = w >> (8 * lane);
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (sx && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (sx && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] m;
    if (sz == 2'd0)      m = 32'hFF << (8 * lane);
    else if (sz == 2'd1) m = 32'hFFFF << (8 * lane);
    else                 m = 32'hFFFF_FFFF;
    return (w & ~m) | ((d << (8 * lane)) & m);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endtask

  // One request: drive at negedge, check response just after the next posedge
  task automatic do_req(input string tag, input logic wen, input logic ren,
                        input logic [AW+1:0] addr, input logic [31:0] din,
                        input logic [1:0] sz, input logic sx);
    logic legal;
    logic exp_rv;
    logic exp_mis;
    int   idx;
    @(negedge clk);
    bus.wen = wen; bus.ren = ren; bus.addr = addr; bus.din = din;
    bus.size = sz; bus.sign_ext = sx;
    legal   = is_legal(addr[1:0], sz);
    idx     = int'(addr[AW+1:2]);
    exp_mis = (wen | ren) & ~legal;
    exp_rv  = ren & ~wen & legal;
    if (exp_rv) exp_dout = model_load(model_mem[idx], addr[1:0], sz, sx);
    if (wen && legal) model_mem[idx] = model_merge(model_mem[idx], addr[1:0], sz, din);
    @(posedge clk);
    #1;
    bus.wen = 1'b0; bus.ren = 1'b0;
    check({tag, " rvalid"}, {31'b0, bus.rvalid}, {31'b0, exp_rv});
    check({tag, " misalign"}, {31'b0, bus.misalign}, {31'b0, exp_mis});
    check({tag, " dout"}, bus.dout, exp_dout);
`ifdef DMEM_PARITY_EN
    check({tag, " parity_err"}, {31'b0, bus.parity_err}, {31'b0, exp_rv & exp_perr});
`endif
    $display("txn %-10s wen=%0b ren=%0b addr=%03h size=%0d sx=%0b din=%08h -> rvalid=%0b mis=%0b dout=%08h",
             tag, wen, ren, addr, sz, sx, din, bus.rvalid, bus.misalign, bus.dout);
  endtask

  // Counts posedges until busy falls; a held load must never respond meanwhile
  task automatic count_busy(output int n);
    int rv_seen;
    n = 0;
    rv_seen = 0;
    bus.ren = 1'b1; bus.wen = 1'b0; bus.addr = 12'h03C; bus.size = 2'd2;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (bus.rvalid || bus.misalign) rv_seen++;
    end while (bus.busy && n < 2000);
    bus.ren = 1'b0;
    check("busy_bounded", {31'b0, bus.busy}, 32'h0);
    check("busy_quiet", rv_seen, 32'h0);
    $display("txn clear busy_edges=%0d", n);
  endtask

  initial begin
    int n;
    bus.addr = '0; bus.din = '0; bus.wen = 1'b0; bus.ren = 1'b0;
    bus.size = 2'd0; bus.sign_ext = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dout", bus.dout, 32'h0);
    check("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
    check("rst_misalign", {31'b0, bus.misalign}, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h1);
    reset = 1'b1;
    count_busy(n);
    check("busy_edges", n, DEPTH);
    model_clear();
    do_req("lw_clr", 0, 1, 12'h03C, 0, 2'd2, 0);

    // Word store then sub-word loads
    do_req("sw", 1, 0, 12'h03C, 32'hCAFEBABE, 2'd2, 0);
    do_req("lw", 0, 1, 12'h03C, 0, 2'd2, 0);
    check("lw_const", bus.dout, 32'hCAFEBABE);
    do_req("lb", 0, 1, 12'h03F, 0, 2'd0, 1);
    check("lb_const", bus.dout, 32'hFFFFFFCA);
    do_req("lbu", 0, 1, 12'h03F, 0, 2'd0, 0);
    do_req("lhu", 0, 1, 12'h03C, 0, 2'd1, 0);
    do_req("idle", 0, 0, 12'h03C, 0, 2'd1, 0);

    // Partial stores into one word
    do_req("sw2", 1, 0, 12'h190, 32'h12345678, 2'd2, 0);
    do_req("sh", 1, 0, 12'h192, 32'hABCDBEEF, 2'd1, 0);
    do_req("sb", 1, 0, 12'h190, 32'h00000099, 2'd0, 0);
    do_req("lw2", 0, 1, 12'h190, 0, 2'd2, 0);
    check("merge_const", bus.dout, 32'hBEEF5699);
    do_req("lh", 0, 1, 12'h192, 0, 2'd1, 1);

    // Illegal requests
    do_req("lw_mis", 0, 1, 12'h191, 0, 2'd2, 0);
    do_req("sh_mis", 1, 0, 12'h193, 32'h1111, 2'd1, 0);
    do_req("lw3", 0, 1, 12'h190, 0, 2'd2, 0);
    do_req("sz11", 0, 1, 12'h190, 0, 2'd3, 0);

    // Store priority and read-after-write
    do_req("wr_rd", 1, 1, 12'h200, 32'h0000ABCD, 2'd2, 0);
    do_req("lw_raw", 0, 1, 12'h200, 0, 2'd2, 0);

    // Reset in the middle of the clear sequence
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, bus.busy}, 32'h1);
    check("mid_rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
    exp_dout = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    count_busy(n);
    check("busy_edges2", n, DEPTH);
    model_clear();
    do_req("lw_clr2", 0, 1, 12'h200, 0, 2'd2, 0);

    // Random traffic over a small window so loads hit stored data
    for (int i = 0; i < 300; i++) begin
      do_req("rand", 1'($urandom % 3 == 0), 1'($urandom % 2),
             12'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 3)),
             1'($urandom % 2));
    end
    do_req("burst_a", 0, 1, 12'h000, 0, 2'd2, 0);
    do_req("burst_b", 0, 1, 12'h004, 0, 2'd2, 0);
    do_req("burst_c", 0, 1, 12'h008, 0, 2'd2, 0);

`ifdef DMEM_PARITY_EN
    // Corrupt one stored bit in lane 1 of word 15 and read it back
    do_req("sw_par", 1, 0, 12'h03C, 32'hCAFEBABE, 2'd2, 0);
    u_dut.g_lane[1].mem_lane[15][1] = ~u_dut.g_lane[1].mem_lane[15][1];
    model_mem[15] = model_mem[15] ^ 32'h0000_0200;
    exp_perr = 1'b1;
    do_req("lw_par", 0, 1, 12'h03C, 0, 2'd2, 0);
    exp_perr = 1'b0;
    do_req("lbu_par", 0, 1, 12'h03C, 0, 2'd0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
